// File: rtl/eqed_pkg.sv
// Shared types and defaults for E-QED signature-capture logic.
// The compaction step is defined once here and used by every MISR-related block.
package eqed_pkg;

   typedef enum logic [1:0] {
      CAP_IDLE,
      CAP_CAPTURE,
      CAP_DONE
   } cap_state_t;

   localparam int                   DEF_WIDTH  = 6;
   localparam logic [DEF_WIDTH-1:0] DEF_POLY   = 6'b110000;
   localparam logic [DEF_WIDTH-1:0] DEF_SEED   = 6'b000001;

   // Widest signature the shared step function supports.
   localparam int MISR_MAX_W = 32;

   // One compaction step on zero-extended operands; callers truncate to their width.
   // Bit 0 takes the tap-mask parity, every other bit takes its lower neighbour.
   function automatic logic [MISR_MAX_W-1:0] misr_step(
      input logic [MISR_MAX_W-1:0] sig,
      input logic [MISR_MAX_W-1:0] d,
      input logic [MISR_MAX_W-1:0] poly
   );
      logic [MISR_MAX_W-1:0] nxt;
      nxt = {sig[MISR_MAX_W-2:0], ^(sig & poly)} ^ d;
      return nxt;
   endfunction

endpackage

// File: rtl/eqed_misr.sv
// Multiple-input signature register: load restores SEED, en compacts one beat of d.
// load wins over en.
module eqed_misr
   import eqed_pkg::*;
#(
   parameter int               WIDTH = DEF_WIDTH,
   parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] sig
);

   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] sig_d;

   // NOTE: default assigned first so every path drives sig_d and no latch is inferred.
   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = SEED;
      end else if (en) begin
         sig_d = WIDTH'(misr_step(MISR_MAX_W'(sig_q), MISR_MAX_W'(d), MISR_MAX_W'(POLY)));
      end
   end

   // NOTE: non-blocking assignment keeps register updates order-independent across blocks.
   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= SEED;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/eqed_sig_capture.sv
// Windowed MISR capture: compacts WINDOW valid beats of din after start, then flags
// done and holds a registered comparison of the final signature against exp_sig.
module eqed_sig_capture
   import eqed_pkg::*;
#(
   parameter int               WIDTH  = DEF_WIDTH,
   parameter int               DIN_W  = 3,
   parameter logic [WIDTH-1:0] POLY   = WIDTH'(DEF_POLY),
   parameter logic [WIDTH-1:0] SEED   = WIDTH'(DEF_SEED),
   parameter int               WINDOW = 5,
   localparam int              CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             din_valid,
   input  logic [DIN_W-1:0] din,
   input  logic [WIDTH-1:0] exp_sig,
   output logic [WIDTH-1:0] sig,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             busy,
   output logic             done,
   output logic             match
);

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WINDOW - 1);

   cap_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match_q, match_d;

   logic             misr_load;
   logic             misr_en;
   logic [WIDTH-1:0] d_ext;
   logic [WIDTH-1:0] sig_cur;
   logic [WIDTH-1:0] sig_step;

   assign d_ext = WIDTH'(din);

   eqed_misr #(
      .WIDTH (WIDTH),
      .POLY  (POLY),
      .SEED  (SEED)
   ) u_misr (
      .clk  (clk),
      .rst  (rst),
      .load (misr_load),
      .en   (misr_en),
      .d    (d_ext),
      .sig  (sig_cur)
   );

   // Value the MISR takes on this edge if the beat is accepted; compared at window close.
   assign sig_step = WIDTH'(misr_step(MISR_MAX_W'(sig_cur), MISR_MAX_W'(d_ext),
                                      MISR_MAX_W'(POLY)));

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      match_d   = match_q;
      misr_load = 1'b0;
      misr_en   = 1'b0;
      unique case (state_q)
         CAP_IDLE, CAP_DONE: begin
            if (start) begin
               misr_load = 1'b1;
               cnt_d     = '0;
               match_d   = 1'b0;
               state_d   = CAP_CAPTURE;
            end
         end
         CAP_CAPTURE: begin
            // start is ignored here; a coinciding final beat still closes the window.
            if (din_valid) begin
               misr_en = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = CAP_DONE;
                  match_d = (sig_step == exp_sig);
               end
            end
         end
         default: begin
            state_d = CAP_IDLE;
            cnt_d   = '0;
            match_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CAP_IDLE;
         cnt_q   <= '0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         match_q <= match_d;
      end
   end

   assign sig      = sig_cur;
   assign beat_cnt = cnt_q;
   assign busy     = (state_q == CAP_CAPTURE);
   assign done     = (state_q == CAP_DONE);
   assign match    = match_q;

endmodule
